// File: rtl/ysyx_23060124_axi_pkg.sv
// Shared encodings for the AXI4 read-only ROM slave: response codes,
// burst types and the read FSM states.
package ysyx_23060124_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_23060124_axi_burst_addr.sv
// Next-beat address generator for 32-bit beats: FIXED holds, INCR steps by 4,
// WRAP steps by 4 inside a (len+1)*4-byte aligned window.
module ysyx_23060124_axi_burst_addr
  import ysyx_23060124_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign incr_addr = addr + ADDR_WIDTH'(4);
  // len is 2^k-1 for any WRAP that reaches here, so {len,2'b11} is window-1
  assign wrap_mask = ADDR_WIDTH'({len, 2'b11});

  always_comb begin
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_axi_rom_slave.sv
// AXI4 read-only memory slave with configurable first-beat latency and a
// side-band preload write port usable while the slave is idle.
module ysyx_23060124_axi_rom_slave
  import ysyx_23060124_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n_sync,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  input  logic [3:0]            S_AXI_ARID,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic [1:0]            S_AXI_ARBURST,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [3:0]            S_AXI_RID,
  output logic                  S_AXI_RLAST,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]            id_reg;
  logic [7:0]            len_reg;
  logic [1:0]            burst_reg;
  logic                  err_reg;
  logic [7:0]            beat_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;
  logic [3:0]            rid_reg;
  logic                  rlast_reg;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ok;
  logic                  rd_last;
  logic                  ar_wrap_bad;
  logic                  ar_err;
  logic [1:0]            ar_burst;

  ysyx_23060124_axi_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_burst_addr (
    .addr     (addr_reg),
    .burst    (burst_reg),
    .len      (len_reg),
    .next_addr(next_addr)
  );

  // While a beat is on the bus the fetch targets the following beat, so an
  // accepted beat is replaced on the same edge without a bubble.
  assign rd_addr = rvalid_reg ? next_addr : addr_reg;
  assign rd_ok   = in_range(rd_addr) && !err_reg;
  assign rd_last = rvalid_reg ? (beat_reg + 8'd1 == len_reg) : (beat_reg == len_reg);

  assign ar_wrap_bad = (S_AXI_ARBURST == BURST_WRAP) && !wrap_len_ok(S_AXI_ARLEN);
  assign ar_err      = (S_AXI_ARSIZE != SIZE_WORD) || (S_AXI_ARBURST == 2'b11) || ar_wrap_bad;
  assign ar_burst    = ((S_AXI_ARBURST == 2'b11) || ar_wrap_bad) ? BURST_INCR : S_AXI_ARBURST;

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en && (state_reg == IDLE) && in_range(wr_addr)) begin
      mem[word_idx(wr_addr)] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      id_reg      <= '0;
      len_reg     <= '0;
      burst_reg   <= BURST_INCR;
      err_reg     <= 1'b0;
      beat_reg    <= '0;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
      rid_reg     <= '0;
      rlast_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (S_AXI_ARVALID && arready_reg) begin
            addr_reg    <= {S_AXI_ARADDR[ADDR_WIDTH-1:2], 2'b00};
            id_reg      <= S_AXI_ARID;
            len_reg     <= S_AXI_ARLEN;
            burst_reg   <= ar_burst;
            err_reg     <= ar_err;
            beat_reg    <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            if (RD_LATENCY == 0) begin
              state_reg <= BURST;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(RD_LATENCY);
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) state_reg <= BURST;
        end
        BURST: begin
          if (!rvalid_reg || S_AXI_RREADY) begin
            if (rvalid_reg && rlast_reg) begin
              state_reg   <= IDLE;
              arready_reg <= 1'b1;
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
            end else begin
              if (rvalid_reg) begin
                beat_reg <= beat_reg + 8'd1;
                addr_reg <= next_addr;
              end
              rvalid_reg <= 1'b1;
              rid_reg    <= id_reg;
              rlast_reg  <= rd_last;
              rresp_reg  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
              rdata_reg  <= rd_ok ? mem[word_idx(rd_addr)] : '0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RID     = rid_reg;
  assign S_AXI_RLAST   = rlast_reg;

endmodule

// File: tb/tb_ysyx_23060124_axi_rom_slave.sv
// Directed self-checking bench for the AXI4 ROM slave: preload, INCR/WRAP/FIXED
// bursts, range and size errors, back-pressure and mid-burst reset.
module tb_ysyx_23060124_axi_rom_slave;
  import ysyx_23060124_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n_sync = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [3:0]  S_AXI_ARID = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = 3'b010;
  logic [1:0]  S_AXI_ARBURST = 2'b01;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [3:0]  S_AXI_RID;
  logic        S_AXI_RLAST;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  ysyx_23060124_axi_rom_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_WORDS (1024),
    .BASE_ADDR (32'h3000_0000),
    .RD_LATENCY(2)
  ) dut (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARID   (S_AXI_ARID),
    .S_AXI_ARLEN  (S_AXI_ARLEN),
    .S_AXI_ARSIZE (S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .S_AXI_RID    (S_AXI_RID),
    .S_AXI_RLAST  (S_AXI_RLAST),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  logic [3:0]  got_id   [16];
  int          got_beats;
  int          got_lat;
  bit          stall_bad;

  logic [31:0] exp_incr [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] exp_wrap [4] = '{32'h33, 32'h44, 32'h11, 32'h22};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one AR, optionally hold RREADY low for 'stall' cycles once RVALID
  // rises, then accept beats either every cycle or every other cycle.
  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input bit alt,
                         input int stall);
    int cyc;
    logic [31:0] snap_data;
    logic [3:0]  snap_id;
    logic        snap_last;
    S_AXI_ARADDR = a;
    S_AXI_ARLEN = len;
    S_AXI_ARSIZE = size;
    S_AXI_ARBURST = burst;
    S_AXI_ARID = id;
    S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_ARREADY && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    wr_en = 1'b0;
    got_lat = 0;
    while (!S_AXI_RVALID && got_lat < 50) begin
      @(posedge clk); #1;
      got_lat++;
    end
    stall_bad = 1'b0;
    snap_data = S_AXI_RDATA;
    snap_id = S_AXI_RID;
    snap_last = S_AXI_RLAST;
    S_AXI_RREADY = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!S_AXI_RVALID || S_AXI_RDATA !== snap_data || S_AXI_RID !== snap_id ||
          S_AXI_RLAST !== snap_last) stall_bad = 1'b1;
    end
    got_beats = 0;
    cyc = 0;
    while (got_beats <= int'(len) && got_beats < 16 && cyc < 200) begin
      S_AXI_RREADY = alt ? (cyc % 2 == 1) : 1'b1;
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        got_data[got_beats] = S_AXI_RDATA;
        got_resp[got_beats] = S_AXI_RRESP;
        got_last[got_beats] = S_AXI_RLAST;
        got_id[got_beats] = S_AXI_RID;
        got_beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n_sync = 1'b1;
    @(posedge clk); #1;
    check_val("reset arready", S_AXI_ARREADY, 1);
    check_val("reset rvalid", S_AXI_RVALID, 0);
    check_val("reset rlast", S_AXI_RLAST, 0);
    check_val("reset rresp", S_AXI_RRESP, 0);
    check_val("reset rid", S_AXI_RID, 0);
    check_val("reset rdata", S_AXI_RDATA, 0);

    preload(BASE + 32'h0, 32'h11);
    preload(BASE + 32'h4, 32'h22);
    preload(BASE + 32'h8, 32'h33);
    preload(BASE + 32'hC, 32'h44);

    // INCR 4 beats, RREADY every other cycle
    do_read(BASE, 8'd3, 3'b010, BURST_INCR, 4'd5, 1'b1, 0);
    check_val("incr latency", got_lat, 3);
    check_val("incr beats", got_beats, 4);
    check_val("arready after rlast", S_AXI_ARREADY, 1);
    check_val("rvalid after rlast", S_AXI_RVALID, 0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("incr data[%0d]", i), got_data[i], exp_incr[i]);
      check_val($sformatf("incr resp[%0d]", i), got_resp[i], 0);
      check_val($sformatf("incr last[%0d]", i), got_last[i], (i == 3) ? 1 : 0);
      check_val($sformatf("incr id[%0d]", i), got_id[i], 5);
    end

    // WRAP 4 beats starting mid-window
    do_read(BASE + 32'h8, 8'd3, 3'b010, BURST_WRAP, 4'd2, 1'b0, 0);
    check_val("wrap beats", got_beats, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("wrap data[%0d]", i), got_data[i], exp_wrap[i]);
      check_val($sformatf("wrap resp[%0d]", i), got_resp[i], 0);
    end

    // single beat just past the end of memory
    do_read(BASE + 32'd4096, 8'd0, 3'b010, BURST_INCR, 4'd1, 1'b0, 0);
    check_val("oor beats", got_beats, 1);
    check_val("oor resp", got_resp[0], 2);
    check_val("oor data", got_data[0], 0);
    check_val("oor last", got_last[0], 1);

    // back-pressure: RREADY low for 5 cycles with RVALID high
    do_read(BASE, 8'd3, 3'b010, BURST_INCR, 4'd7, 1'b0, 5);
    check_val("stall outputs held", stall_bad, 0);
    check_val("stall data[0]", got_data[0], 32'h11);
    check_val("stall data[1]", got_data[1], 32'h22);
    check_val("stall id", got_id[0], 7);

    // narrow size -> SLVERR on every beat
    do_read(BASE, 8'd1, 3'b001, BURST_INCR, 4'd3, 1'b0, 0);
    check_val("size beats", got_beats, 2);
    check_val("size resp[0]", got_resp[0], 2);
    check_val("size resp[1]", got_resp[1], 2);
    check_val("size data[0]", got_data[0], 0);

    // preload write in the same cycle as the AR handshake
    wr_en = 1'b1;
    wr_addr = BASE + 32'h10;
    wr_data = 32'h55;
    do_read(BASE + 32'h10, 8'd0, 3'b010, BURST_INCR, 4'd4, 1'b0, 0);
    check_val("same-cycle write data", got_data[0], 32'h55);
    check_val("same-cycle write resp", got_resp[0], 0);

    // FIXED burst repeats one word
    do_read(BASE + 32'h4, 8'd1, 3'b010, BURST_FIXED, 4'd6, 1'b0, 0);
    check_val("fixed data[0]", got_data[0], 32'h22);
    check_val("fixed data[1]", got_data[1], 32'h22);
    check_val("fixed last[1]", got_last[1], 1);

    // WRAP with illegal length -> INCR with SLVERR
    do_read(BASE + 32'h4, 8'd2, 3'b010, BURST_WRAP, 4'd8, 1'b0, 0);
    check_val("badwrap beats", got_beats, 3);
    check_val("badwrap resp[0]", got_resp[0], 2);
    check_val("badwrap resp[2]", got_resp[2], 2);
    check_val("badwrap data[1]", got_data[1], 0);

    // INCR crossing the top of memory
    do_read(BASE + 32'hFFC, 8'd1, 3'b010, BURST_INCR, 4'd2, 1'b0, 0);
    check_val("edge resp[0]", got_resp[0], 0);
    check_val("edge resp[1]", got_resp[1], 2);
    check_val("edge data[1]", got_data[1], 0);

    // reset while beat 2 of a 4-beat burst is on the bus
    S_AXI_ARADDR = BASE;
    S_AXI_ARLEN = 8'd3;
    S_AXI_ARSIZE = 3'b010;
    S_AXI_ARBURST = BURST_INCR;
    S_AXI_ARID = 4'd9;
    S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 50 && !S_AXI_RVALID; i++) begin
      @(posedge clk); #1;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    check_val("midburst beat2 data", S_AXI_RDATA, 32'h22);
    S_AXI_RREADY = 1'b0;
    rst_n_sync = 1'b0;
    @(posedge clk); #1;
    check_val("midburst rst rvalid", S_AXI_RVALID, 0);
    check_val("midburst rst rid", S_AXI_RID, 0);
    rst_n_sync = 1'b1;
    @(posedge clk); #1;
    check_val("post-rst arready", S_AXI_ARREADY, 1);
    check_val("post-rst rvalid", S_AXI_RVALID, 0);
    check_val("post-rst rlast", S_AXI_RLAST, 0);
    do_read(BASE, 8'd3, 3'b010, BURST_INCR, 4'd1, 1'b0, 0);
    check_val("post-rst beats", got_beats, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("post-rst data[%0d]", i), got_data[i], exp_incr[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_axi_rom_slave.md
YSYX_23060124_AXI_ROM_SLAVE -- requirements
Module: ysyx_23060124_axi_rom_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in words (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte address of word 0.
REQ-005 SHALL have parameter RD_LATENCY, default 2, wait cycles between the AR handshake and the first beat (0..15).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n_sync, input, 1, synchronous active-low reset.
REQ-008 SHALL have ports S_AXI_ARADDR in 32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARID in 4, each carrying its AXI4 read-address meaning.
REQ-009 SHALL have ports S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2, carrying beats-1, beat size and burst type.
REQ-010 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RID out 4, S_AXI_RLAST out 1, each carrying its AXI4 read-data meaning.
REQ-011 SHALL have ports wr_en in 1, wr_addr in 32, wr_data in 32, a side-band preload write port.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, BURST; IDLE drives ARREADY=1, all other states drive ARREADY=0.
REQ-013 SHALL, on ARVALID&&ARREADY, capture word-aligned ARADDR, ARID, ARLEN, ARBURST and an error flag, then go to WAIT loaded with RD_LATENCY, or directly to BURST if RD_LATENCY=0.
REQ-014 SHALL decrement the WAIT counter once per cycle and enter BURST when it reaches 0; first RVALID appears RD_LATENCY+1 cycles after the handshake cycle.
REQ-015 SHALL in BURST drive RVALID=1, RID=captured ID, RDATA=mem[(addr-BASE_ADDR)>>2], RLAST=1 only when beat count equals captured ARLEN.
REQ-016 SHALL hold RDATA, RRESP, RID and RLAST stable while RVALID&&!RREADY; RREADY may pulse or stay low indefinitely.
REQ-017 SHALL on each RVALID&&RREADY increment the beat count and advance the address: FIXED holds, INCR adds 4, WRAP adds 4 within a (ARLEN+1)*4-byte aligned window.
REQ-018 SHALL return to IDLE after the RLAST handshake; ARREADY rises the following cycle, with no overlap of bursts.
REQ-019 SHALL flag SLVERR (RRESP=2'b10, RDATA=0) on any beat whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4), and on all beats if ARSIZE!=3'b010 or ARBURST=2'b11 (treated as INCR); otherwise RRESP=2'b00.
REQ-020 SHALL apply a WRAP with ARLEN outside {1,3,7,15} as INCR with SLVERR.
REQ-021 SHALL write wr_data to word (wr_addr-BASE_ADDR)>>2 at the clock edge only in IDLE with an in-range address; otherwise the write is ignored.
REQ-022 SHALL allow an AR handshake and a preload write in the same IDLE cycle; the burst then reads the newly written value.

Reset
REQ-023 SHALL on rst_n_sync=0 force state IDLE, ARREADY=1 after release, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, and clear the counters, including mid-burst.
REQ-024 SHALL NOT clear memory contents on reset.

Structure
REQ-025 SHALL take RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP and the FSM state enum from shared package ysyx_23060124_axi_pkg.
REQ-026 SHALL place next-beat address generation (FIXED/INCR/WRAP) in sub-module ysyx_23060124_axi_burst_addr; the memory array stays inline.

Verification
REQ-027 SHALL test: preload BASE+0x0..0xC = 0x11,0x22,0x33,0x44; INCR ARLEN=3 at BASE, RD_LATENCY=2, RREADY every other cycle -> beats 0x11,0x22,0x33,0x44, RLAST on beat 4 only, first RVALID 3 cycles after AR.
REQ-028 SHALL test: WRAP ARLEN=3 at BASE+0x8 -> beats 0x33,0x44,0x11,0x22, RRESP=0 on all.
REQ-029 SHALL test: ARLEN=0 at BASE+MEM_WORDS*4 -> one beat, RRESP=2'b10, RDATA=0, RLAST=1.
REQ-030 SHALL test: RREADY low for 5 cycles with RVALID high -> RDATA/RID/RLAST unchanged, beat not advanced.
REQ-031 SHALL test: reset during beat 2 of a 4-beat burst -> RVALID=0, ARREADY=1 after release; a repeat read returns the preloaded data.
REQ-032 SHALL test: ARSIZE=3'b001, ARLEN=1 -> two beats, both RRESP=2'b10.
